// File: rtl/bp_be_fe_queue_rx.sv
// Backend side of the FE->BE fetch queue. Entries are read speculatively
// by issue, retired by commit and replayed by roll. A redirect flushes the
// queue and sends a PC redirection command back to the frontend.
//
// fe_cmd_o layout, LSB first:
//   [3:0]                    opcode
//   [vaddr_width_p+3:4]      npc
//   [fe_cmd_width_lp-1:...]  operands (zero for a PC redirection)

package bp_be_fe_queue_rx_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [3:0] {
        e_op_state_reset    = 4'd0,
        e_op_pc_redirection = 4'd1,
        e_op_icache_fill    = 4'd2,
        e_op_wait           = 4'd3
    } bp_fe_command_op_e;

    localparam int fe_cmd_opcode_width_gp  = 4;
    localparam int fe_cmd_operand_width_gp = 32;

    function automatic int bp_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

    // Packet from FE: message type (2) + PC + 32-bit instruction.
    function automatic int bp_fe_queue_width(input bp_params_e cfg);
        return 2 + bp_vaddr_width(cfg) + 32;
    endfunction

    function automatic int bp_fe_cmd_width(input bp_params_e cfg);
        return fe_cmd_opcode_width_gp + bp_vaddr_width(cfg) + fe_cmd_operand_width_gp;
    endfunction

endpackage

module bp_be_fe_queue_rx
    import bp_be_fe_queue_rx_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int els_p = 8,
    localparam int vaddr_width_p     = bp_vaddr_width(bp_params_p),
    localparam int fe_queue_width_lp = bp_fe_queue_width(bp_params_p),
    localparam int fe_cmd_width_lp   = bp_fe_cmd_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_and_o,

    output logic [fe_queue_width_lp-1:0] issue_pkt_o,
    output logic                         issue_v_o,
    input  logic                         issue_yumi_i,

    input  logic                         commit_v_i,
    input  logic                         roll_v_i,

    input  logic                         redirect_v_i,
    input  logic [vaddr_width_p-1:0]     redirect_pc_i,

    output logic [fe_cmd_width_lp-1:0]   fe_cmd_o,
    output logic                         fe_cmd_v_o,
    input  logic                         fe_cmd_yumi_i
);

    // Handshakes (all sampled on the rising edge of clk_i):
    //   FE:     transfer when fe_queue_v_i & fe_queue_ready_and_o; the
    //           packet is dropped while fe_cmd_v_o is high or on redirect.
    //   issue:  issue_yumi_i may only be raised while issue_v_o is high;
    //           it consumes issue_pkt_o in that same cycle.
    //   fe_cmd: fe_cmd_yumi_i consumes fe_cmd_o while fe_cmd_v_o is high.

    localparam int idx_w_lp = $clog2(els_p);
    localparam int ptr_w_lp = idx_w_lp + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef logic [ptr_w_lp-1:0] ptr_t;

    logic [fe_queue_width_lp-1:0] entries_q [els_p];

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t cptr_q, cptr_d;

    logic [0:0]                 state_q, state_d;
    logic [fe_cmd_width_lp-1:0] fe_cmd_q, fe_cmd_d;

    logic full;
    logic enq_write;

    // Full when write has lapped commit by exactly one wrap.
    always_comb begin
        full = (wptr_q[idx_w_lp-1:0] == cptr_q[idx_w_lp-1:0])
             & (wptr_q[idx_w_lp] != cptr_q[idx_w_lp]);
    end

    assign fe_queue_ready_and_o = ~full;
    assign fe_cmd_v_o           = (state_q == ST_SEND);
    assign fe_cmd_o             = fe_cmd_q;
    assign issue_v_o            = (rptr_q != wptr_q) & ~fe_cmd_v_o;
    assign issue_pkt_o          = entries_q[rptr_q[idx_w_lp-1:0]];

    // Packets arriving while a command is outstanding belong to the
    // stale path and are accepted but not stored.
    assign enq_write = fe_queue_v_i & ~full & ~fe_cmd_v_o & ~redirect_v_i;

    // Pointer next-state: redirect > roll > {commit, yumi, enqueue}.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (redirect_v_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cptr_d = '0;
        end else begin
            if (commit_v_i) begin
                cptr_d = cptr_q + ptr_t'(1);
            end
            if (roll_v_i) begin
                rptr_d = cptr_d;
            end else if (issue_yumi_i) begin
                rptr_d = rptr_q + ptr_t'(1);
            end
            if (enq_write) begin
                wptr_d = wptr_q + ptr_t'(1);
            end
        end
    end

    // fe_cmd FSM: a redirect always (re)loads the payload, even over a yumi.
    always_comb begin
        state_d  = state_q;
        fe_cmd_d = fe_cmd_q;
        if (redirect_v_i) begin
            state_d  = ST_SEND;
            fe_cmd_d = {{fe_cmd_operand_width_gp{1'b0}}, redirect_pc_i, e_op_pc_redirection};
        end else if ((state_q == ST_SEND) && fe_cmd_yumi_i) begin
            state_d = ST_IDLE;
        end
    end

    // Pointer and FSM registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cptr_q   <= '0;
            state_q  <= ST_IDLE;
            fe_cmd_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cptr_q   <= cptr_d;
            state_q  <= state_d;
            fe_cmd_q <= fe_cmd_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq_write) begin
            entries_q[wptr_q[idx_w_lp-1:0]] <= fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    yumi_without_valid_a: assert property (@(posedge clk_i) disable iff (reset_i)
        issue_yumi_i |-> issue_v_o);
    commit_without_read_a: assert property (@(posedge clk_i) disable iff (reset_i)
        commit_v_i |-> (cptr_q != rptr_q));
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_rx.sv
// Bench for bp_be_fe_queue_rx: a behavioural model keeps two queues
// (waiting-to-issue and issued-but-uncommitted) and a pending-command
// flag; every cycle the DUT outputs are compared against it.
module tb_bp_be_fe_queue_rx;
    import bp_be_fe_queue_rx_pkg::*;

    localparam int ELS   = 8;
    localparam int VA_W  = bp_vaddr_width(e_bp_default_cfg);
    localparam int FEQ_W = bp_fe_queue_width(e_bp_default_cfg);
    localparam int CMD_W = bp_fe_cmd_width(e_bp_default_cfg);

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [FEQ_W-1:0] fe_queue_i;
    logic             fe_queue_v_i;
    logic             fe_queue_ready_and_o;
    logic [FEQ_W-1:0] issue_pkt_o;
    logic             issue_v_o;
    logic             issue_yumi_i;
    logic             commit_v_i;
    logic             roll_v_i;
    logic             redirect_v_i;
    logic [VA_W-1:0]  redirect_pc_i;
    logic [CMD_W-1:0] fe_cmd_o;
    logic             fe_cmd_v_o;
    logic             fe_cmd_yumi_i;

    int tests = 0;
    int fails = 0;

    logic [FEQ_W-1:0] exp_q[$];
    logic [FEQ_W-1:0] infl_q[$];
    bit               cmd_v_m;
    logic [VA_W-1:0]  cmd_pc_m;

    bp_be_fe_queue_rx #(.bp_params_p(e_bp_default_cfg), .els_p(ELS)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i),
        .fe_queue_ready_and_o(fe_queue_ready_and_o),
        .issue_pkt_o(issue_pkt_o), .issue_v_o(issue_v_o), .issue_yumi_i(issue_yumi_i),
        .commit_v_i(commit_v_i), .roll_v_i(roll_v_i),
        .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i),
        .fe_cmd_o(fe_cmd_o), .fe_cmd_v_o(fe_cmd_v_o), .fe_cmd_yumi_i(fe_cmd_yumi_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    function automatic logic [FEQ_W-1:0] tag(input int t);
        logic [FEQ_W-1:0] v;
        v = FEQ_W'(64'h5A5A_0000_0000_0000) | FEQ_W'(t);
        return v;
    endfunction

    // Driver + scoreboard: called at posedge+1, drives one cycle of inputs,
    // compares outputs against the model, updates the model, advances.
    task automatic cycle(input bit enq, input logic [FEQ_W-1:0] d, input bit yumi,
                         input bit commit, input bit roll, input bit redir,
                         input logic [VA_W-1:0] pc, input bit cyumi, input bit rst);
        bit full_m;
        bit acc;
        logic [CMD_W-1:0] exp_cmd;
        fe_queue_v_i  = enq;
        fe_queue_i    = d;
        issue_yumi_i  = yumi;
        commit_v_i    = commit;
        roll_v_i      = roll;
        redirect_v_i  = redir;
        redirect_pc_i = pc;
        fe_cmd_yumi_i = cyumi;
        reset_i       = rst;
        #1;
        full_m = (exp_q.size() + infl_q.size()) == ELS;
        tests++;
        if (fe_queue_ready_and_o !== !full_m) begin
            fails++;
            $display("FAIL ready: got %b expected %b", fe_queue_ready_and_o, !full_m);
        end
        tests++;
        if (issue_v_o !== (exp_q.size() != 0 && !cmd_v_m)) begin
            fails++;
            $display("FAIL issue_v: got %b expected %b", issue_v_o, (exp_q.size() != 0 && !cmd_v_m));
        end
        if (exp_q.size() != 0 && !cmd_v_m) begin
            tests++;
            if (issue_pkt_o !== exp_q[0]) begin
                fails++;
                $display("FAIL issue_pkt: got %h expected %h", issue_pkt_o, exp_q[0]);
            end
        end
        tests++;
        if (fe_cmd_v_o !== cmd_v_m) begin
            fails++;
            $display("FAIL fe_cmd_v: got %b expected %b", fe_cmd_v_o, cmd_v_m);
        end
        if (cmd_v_m) begin
            exp_cmd = {32'h0, cmd_pc_m, 4'h1};
            tests++;
            if (fe_cmd_o !== exp_cmd) begin
                fails++;
                $display("FAIL fe_cmd: got %h expected %h", fe_cmd_o, exp_cmd);
            end
        end
        // model update
        if (rst) begin
            exp_q.delete();
            infl_q.delete();
            cmd_v_m = 1'b0;
        end else if (redir) begin
            exp_q.delete();
            infl_q.delete();
            cmd_v_m  = 1'b1;
            cmd_pc_m = pc;
        end else begin
            acc = enq && !full_m && !cmd_v_m;
            if (cmd_v_m && cyumi) cmd_v_m = 1'b0;
            if (commit && infl_q.size() != 0) void'(infl_q.pop_front());
            if (roll) begin
                for (int i = infl_q.size() - 1; i >= 0; i--) exp_q.push_front(infl_q[i]);
                infl_q.delete();
            end else if (yumi && exp_q.size() != 0) begin
                infl_q.push_back(exp_q.pop_front());
            end
            if (acc) exp_q.push_back(d);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || infl_q.size() != 0 || cmd_v_m) && n < 64) begin
            cycle(0, '0, exp_q.size() != 0 && !cmd_v_m, infl_q.size() != 0, 0, 0, '0, cmd_v_m, 0);
            n++;
        end
        tests++;
        if (n >= 64) begin
            fails++;
            $display("FAIL drain_timeout: got %0d cycles expected < 64", n);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (fe_queue_ready_and_o !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b expected 1", fe_queue_ready_and_o);
        end
        tests++;
        if (issue_v_o !== 1'b0) begin
            fails++; $display("FAIL reset_issue_v: got %b expected 0", issue_v_o);
        end
        tests++;
        if (fe_cmd_v_o !== 1'b0) begin
            fails++; $display("FAIL reset_fe_cmd_v: got %b expected 0", fe_cmd_v_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) cycle(1, tag('hA0 + i), 0, 0, 0, 0, '0, 0, 0);
        tests++;
        if (fe_queue_ready_and_o !== 1'b0) begin
            fails++; $display("FAIL fill_full: got %b expected 0", fe_queue_ready_and_o);
        end
        cycle(1, tag('hEE), 0, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (issue_pkt_o !== tag('hA0 + i)) begin
                fails++; $display("FAIL fill_order: got %h expected %h", issue_pkt_o, tag('hA0 + i));
            end
            cycle(0, '0, 1, 0, 0, 0, '0, 0, 0);
        end
        for (int i = 0; i < 8; i++) cycle(0, '0, 0, 1, 0, 0, '0, 0, 0);
        tests++;
        if (fe_queue_ready_and_o !== 1'b1 || issue_v_o !== 1'b0) begin
            fails++; $display("FAIL fill_drained: got ready=%b issue_v=%b expected ready=1 issue_v=0",
                              fe_queue_ready_and_o, issue_v_o);
        end
    endtask

    task automatic test_roll();
        for (int i = 0; i < 4; i++) cycle(1, tag('hB0 + i), 0, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0, 0, '0, 0, 0);
        cycle(0, '0, 0, 1, 0, 0, '0, 0, 0);
        cycle(0, '0, 1, 0, 1, 0, '0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (issue_pkt_o !== tag('hB0 + i)) begin
                fails++; $display("FAIL roll_replay: got %h expected %h", issue_pkt_o, tag('hB0 + i));
            end
            cycle(0, '0, 1, 0, 0, 0, '0, 0, 0);
        end
        drain();
    endtask

    task automatic test_commit_roll();
        for (int i = 0; i < 4; i++) cycle(1, tag('hC0 + i), 0, 0, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0, 0, '0, 0, 0);
        cycle(0, '0, 0, 1, 0, 0, '0, 0, 0);
        cycle(0, '0, 0, 1, 1, 0, '0, 0, 0);
        tests++;
        if (issue_pkt_o !== tag('hC2)) begin
            fails++; $display("FAIL commit_roll: got %h expected %h", issue_pkt_o, tag('hC2));
        end
        drain();
    endtask

    task automatic test_redirect();
        logic [VA_W-1:0] pc;
        pc = VA_W'(32'h8000_1000);
        for (int i = 0; i < 3; i++) cycle(1, tag('hD0 + i), 0, 0, 0, 0, '0, 0, 0);
        cycle(0, '0, 0, 0, 0, 1, pc, 0, 0);
        tests++;
        if (fe_cmd_v_o !== 1'b1 || fe_cmd_o[4 +: VA_W] !== pc || issue_v_o !== 1'b0) begin
            fails++; $display("FAIL redirect: got v=%b npc=%h issue_v=%b expected v=1 npc=%h issue_v=0",
                              fe_cmd_v_o, fe_cmd_o[4 +: VA_W], issue_v_o, pc);
        end
        tests++;
        if (fe_cmd_o[3:0] !== 4'h1) begin
            fails++; $display("FAIL redirect_op: got %h expected 1", fe_cmd_o[3:0]);
        end
        cycle(1, tag('hD8), 0, 0, 0, 0, '0, 0, 0);
        cycle(1, tag('hD9), 0, 0, 0, 0, '0, 1, 0);
        cycle(1, tag('hDA), 0, 0, 0, 0, '0, 0, 0);
        tests++;
        if (issue_v_o !== 1'b1 || issue_pkt_o !== tag('hDA)) begin
            fails++; $display("FAIL redirect_resume: got v=%b pkt=%h expected v=1 pkt=%h",
                              issue_v_o, issue_pkt_o, tag('hDA));
        end
        drain();
    endtask

    task automatic test_double_redirect();
        cycle(0, '0, 0, 0, 0, 1, VA_W'(12'h100), 0, 0);
        cycle(0, '0, 0, 0, 0, 1, VA_W'(12'h200), 1, 0);
        tests++;
        if (fe_cmd_v_o !== 1'b1 || fe_cmd_o[4 +: VA_W] !== VA_W'(12'h200)) begin
            fails++; $display("FAIL double_redirect: got v=%b npc=%h expected v=1 npc=200",
                              fe_cmd_v_o, fe_cmd_o[4 +: VA_W]);
        end
        cycle(0, '0, 0, 0, 0, 0, '0, 1, 0);
        tests++;
        if (fe_cmd_v_o !== 1'b0) begin
            fails++; $display("FAIL cmd_release: got %b expected 0", fe_cmd_v_o);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++)
            cycle(1, tag('hE0 + i), exp_q.size() != 0, infl_q.size() != 0, 0, 0, '0, 0, 0);
        drain();
        tests++;
        if (fe_queue_ready_and_o !== 1'b1 || issue_v_o !== 1'b0) begin
            fails++; $display("FAIL wrap_end: got ready=%b issue_v=%b expected 1/0",
                              fe_queue_ready_and_o, issue_v_o);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, tag('hF0), 0, 0, 0, 0, '0, 0, 0);
        cycle(1, tag('hF1), 1, 0, 0, 0, '0, 0, 0);
        cycle(0, '0, 0, 0, 0, 1, VA_W'(16'h4440), 0, 0);
        cycle(1, tag('hF2), 0, 0, 0, 1, VA_W'(16'h5550), 1, 1);
        tests++;
        if (fe_cmd_v_o !== 1'b0 || issue_v_o !== 1'b0 || fe_queue_ready_and_o !== 1'b1) begin
            fails++; $display("FAIL reset_mid: got cmd_v=%b issue_v=%b ready=%b expected 0/0/1",
                              fe_cmd_v_o, issue_v_o, fe_queue_ready_and_o);
        end
        idle();
    endtask

    task automatic test_random();
        bit en, yu, co, ro, rd, cy;
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 3) != 0;
            yu = (exp_q.size() != 0 && !cmd_v_m) && ($urandom_range(0, 2) != 0);
            co = (infl_q.size() != 0) && ($urandom_range(0, 2) != 0);
            ro = $urandom_range(0, 15) == 0;
            rd = $urandom_range(0, 40) == 0;
            cy = cmd_v_m && ($urandom_range(0, 1) != 0);
            cycle(en, {$urandom, $urandom, $urandom}, yu, co, ro, rd,
                  VA_W'({$urandom, $urandom}), cy, 0);
        end
        drain();
    endtask

    initial begin
        reset_i = 1'b1; fe_queue_v_i = 0; fe_queue_i = '0; issue_yumi_i = 0;
        commit_v_i = 0; roll_v_i = 0; redirect_v_i = 0; redirect_pc_i = '0; fe_cmd_yumi_i = 0;
        cmd_v_m = 1'b0; cmd_pc_m = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        test_reset();
        test_fill();
        test_roll();
        test_commit_roll();
        test_redirect();
        test_double_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
